alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/alu_issue.sv | 125 ++++++++++++
 tb/tb_alu_issue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and issue FSM encoding
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SRA = 3'b101;
   localparam logic [2:0] OP_UGT = 3'b110;
   localparam logic [2:0] OP_SGT = 3'b111;

   localparam int OPND_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command FIFO, power-of-two depth, count-based full/empty
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 71
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic                       pop_valid_o,
   output logic [W-1:0]               pop_data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign push_ready_o = (count_q < CW'(DEPTH));
   assign pop_valid_o  = (count_q != '0);
   assign do_push      = push_valid_i && push_ready_o;
   assign do_pop       = pop_i && pop_valid_o;
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign count_o      = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - queues ALU commands, issues them to an external ALU, holds results
module alu_issue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [31:0]       cmd_a,
   input  logic [31:0]       cmd_b,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [2:0]        alu_op,
   input  logic [31:0]       alu_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [31:0]       res_data,
   output logic [TAG_W-1:0]  res_tag,
   output logic              res_zero
);

   localparam int PW = 3 + 2 * OPND_W + TAG_W;
   localparam int CW = $clog2(DEPTH) + 1;

   state_e              state_q;
   logic [31:0]         alu_a_q, alu_b_q;
   logic [2:0]          alu_op_q;
   logic [TAG_W-1:0]    tag_q;
   logic                res_valid_q, res_zero_q;
   logic [31:0]         res_data_q;
   logic [TAG_W-1:0]    res_tag_q;

   logic [PW-1:0]       head;
   logic                fifo_nonempty, fifo_pop;
   logic [CW-1:0]       fifo_count;
   logic [2:0]          head_op;
   logic [31:0]         head_a, head_b;
   logic [TAG_W-1:0]    head_tag;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (PW)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (cmd_valid),
      .push_ready_o (cmd_ready),
      .push_data_i  ({cmd_op, cmd_a, cmd_b, cmd_tag}),
      .pop_i        (fifo_pop),
      .pop_valid_o  (fifo_nonempty),
      .pop_data_o   (head),
      .count_o      (fifo_count)
   );

   assign head_op  = head[PW-1 -: 3];
   assign head_a   = head[TAG_W+63 -: 32];
   assign head_b   = head[TAG_W+31 -: 32];
   assign head_tag = head[TAG_W-1:0];

   // A new command leaves the FIFO from IDLE, or in HOLD on the same edge the result is taken.
   assign fifo_pop = fifo_nonempty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= OP_ADD;
         tag_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  alu_a_q  <= head_a;
                  alu_b_q  <= head_b;
                  alu_op_q <= head_op;
                  tag_q    <= head_tag;
                  state_q  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               res_data_q  <= alu_c;
               res_zero_q  <= (alu_c == '0);
               res_tag_q   <= tag_q;
               res_valid_q <= 1'b1;
               state_q     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  if (fifo_pop) begin
                     alu_a_q  <= head_a;
                     alu_b_q  <= head_b;
                     alu_op_q <= head_op;
                     tag_q    <= head_tag;
                     state_q  <= ST_ISSUE;
                  end else begin
                     state_q  <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_tag   = res_tag_q;
   assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural external ALU
module tb_alu_issue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op = '0;
   logic [31:0]       cmd_a = '0;
   logic [31:0]       cmd_b = '0;
   logic [TAG_W-1:0]  cmd_tag = '0;
   logic [31:0]       alu_a, alu_b, alu_c;
   logic [2:0]        alu_op;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [31:0]       res_data;
   logic [TAG_W-1:0]  res_tag;
   logic              res_zero;

   alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_tag   (cmd_tag),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .res_zero  (res_zero)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_c = '0;
      case (alu_op)
         OP_ADD:  alu_c = alu_a + alu_b;
         OP_SUB:  alu_c = alu_a - alu_b;
         OP_AND:  alu_c = alu_a & alu_b;
         OP_OR:   alu_c = alu_a | alu_b;
         OP_SRL:  alu_c = alu_a >> alu_b[4:0];
         OP_SRA:  alu_c = $signed(alu_a) >>> alu_b[4:0];
         OP_UGT:  alu_c = {31'd0, alu_a > alu_b};
         OP_SGT:  alu_c = {31'd0, $signed(alu_a) > $signed(alu_b)};
         default: alu_c = '0;
      endcase
   end

   typedef struct {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             zero;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_hs = -1;
   bit   gap_chk = 1'b0;

   localparam logic [2:0] S_OP [16] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SRL, OP_SRA, OP_UGT, OP_SGT,
                                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SRL, OP_SRA, OP_UGT, OP_SGT};
   localparam logic [31:0] S_A [16] = '{32'd10, 32'd100, 32'h0000F0F0, 32'h0000F000,
                                        32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFFF, 32'd3, 32'hFFFF0000, 32'd0,
                                        32'h12345678, 32'h7FFFFFF0, 32'd2, 32'd5};
   localparam logic [31:0] S_B [16] = '{32'd20, 32'd1, 32'h00000FF0, 32'h0000000F,
                                        32'd4, 32'd4, 32'd1, 32'd1,
                                        32'd1, 32'd5, 32'h00FFFF00, 32'd0,
                                        32'd8, 32'd4, 32'd3, 32'hFFFFFFFB};
   localparam logic [31:0] S_E [16] = '{32'd30, 32'd99, 32'h000000F0, 32'h0000F00F,
                                        32'h08000000, 32'hF8000000, 32'd1, 32'd0,
                                        32'd0, 32'hFFFFFFFE, 32'h00FF0000, 32'd0,
                                        32'h00123456, 32'h07FFFFFF, 32'd0, 32'd1};

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got tag %0d data %h expected no result", res_tag, res_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_data", res_data, mon_e.data);
            chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
            chk("res_zero", 32'(res_zero), 32'(mon_e.zero));
         end
         if (gap_chk) begin
            if (last_hs >= 0) chk("res_gap", 32'(cyc - last_hs), 32'd2);
            last_hs = cyc;
         end
      end
   end

   task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_timeout: got cmd_ready 0 expected 1 for tag %0d", tag);
      end else begin
         exp_q.push_back('{data: exp, tag: tag, zero: (exp == 32'd0)});
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"}, res_data, 32'd0);
      chk({tag, "_res_tag"}, 32'(res_tag), 32'd0);
      chk({tag, "_res_zero"}, 32'(res_zero), 32'd0);
      chk({tag, "_alu_a"}, alu_a, 32'd0);
      chk({tag, "_alu_b"}, alu_b, 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single command latency
      res_ready = 1'b1;
      push(OP_ADD, 32'd5, 32'd3, 4'd1, 32'd8);
      chk("lat_alu_a_early", alu_a, 32'd0);
      @(posedge clk);
      #1;
      chk("lat_alu_op", 32'(alu_op), 32'(OP_ADD));
      chk("lat_alu_a", alu_a, 32'd5);
      chk("lat_alu_b", alu_b, 32'd3);
      chk("lat_res_valid_early", 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_res_valid", 32'(res_valid), 32'd1);
      chk("lat_res_data", res_data, 32'd8);
      chk("lat_res_tag", 32'(res_tag), 32'd1);
      drain();

      // backpressure
      res_ready = 1'b0;
      push(OP_ADD, 32'd1, 32'd2, 4'd2, 32'd3);
      push(OP_OR, 32'h10, 32'h01, 4'd3, 32'h11);
      push(OP_SRL, 32'h100, 32'd4, 4'd4, 32'h10);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_res_valid", 32'(res_valid), 32'd1);
         chk("bp_res_data", res_data, 32'd3);
         chk("bp_res_tag", 32'(res_tag), 32'd2);
         chk("bp_alu_a", alu_a, 32'd1);
         chk("bp_alu_b", alu_b, 32'd2);
         chk("bp_count", 32'(dut.fifo_count), 32'd2);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      drain();

      // full FIFO
      res_ready = 1'b0;
      push(OP_AND, 32'hFF, 32'h0F, 4'd5, 32'h0F);
      push(OP_SUB, 32'd10, 32'd4, 4'd6, 32'd6);
      push(OP_SRA, 32'hFFFFFF00, 32'd4, 4'd7, 32'hFFFFFFF0);
      push(OP_UGT, 32'd5, 32'd4, 4'd8, 32'd1);
      push(OP_ADD, 32'h7FFFFFFF, 32'd1, 4'd9, 32'h80000000);
      chk("full_count", 32'(dut.fifo_count), 32'd4);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_op    = OP_OR;
      cmd_a     = 32'hA0;
      cmd_b     = 32'h05;
      cmd_tag   = 4'd10;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_hold_ready", 32'(cmd_ready), 32'd0);
         chk("full_hold_count", 32'(dut.fifo_count), 32'd4);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      push(OP_OR, 32'hA0, 32'h05, 4'd10, 32'hA5);
      drain();

      // zero flag
      push(OP_SUB, 32'd7, 32'd7, 4'd11, 32'd0);
      drain();

      // mid-run reset
      res_ready = 1'b0;
      push(OP_ADD, 32'd1, 32'd1, 4'd12, 32'd2);
      push(OP_ADD, 32'd2, 32'd2, 4'd13, 32'd4);
      push(OP_ADD, 32'd3, 32'd3, 4'd14, 32'd6);
      push(OP_ADD, 32'd4, 32'd4, 4'd15, 32'd8);
      chk("mr_res_valid_pre", 32'(res_valid), 32'd1);
      chk("mr_count_pre", 32'(dut.fifo_count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("mr_no_result", 32'(res_valid), 32'd0);
         chk("mr_count", 32'(dut.fifo_count), 32'd0);
      end
      @(posedge clk);
      #1;

      // streaming
      last_hs = -1;
      gap_chk = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(S_OP[i], S_A[i], S_B[i], TAG_W'(i), S_E[i]);
      end
      drain();
      gap_chk = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
